// File: rtl/fod_spi_regs.sv
// SPI mode-0 slave with a 16-bit frame {RW, ADDR[3:0], DATA[10:0]} that
// drives the FOD calibration and loop configuration registers. Every
// SPI input is resynchronised into CLK. FCW_FOD changes atomically:
// a write to the low-half shadow is staged, and the write to the high
// half loads the whole word.
module fod_spi_regs (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCLK,
  input  logic        CSN,
  input  logic        MOSI,
  output logic        MISO,
  output logic        CFG_UPD,
  output logic        PCALI_EN,
  output logic        FREQ_C_EN,
  output logic        FREQ_C_MODE,
  output logic        RT_EN,
  output logic        DTCCALI_EN,
  output logic        OFSTCALI_EN,
  output logic [4:0]  FREQ_C_KS,
  output logic [4:0]  PCALI_KS,
  output logic [4:0]  KB,
  output logic [4:0]  KC,
  output logic [4:0]  KD,
  output logic [9:0]  PHASE_CTRL,
  output logic [9:0]  KDTCB_INIT,
  output logic [9:0]  KDTCC_INIT,
  output logic [9:0]  KDTCD_INIT,
  output logic [2:0]  PCALI_FREQDOWN,
  output logic [1:0]  PSEG,
  output logic [1:0]  CALIORDER,
  output logic [21:0] FCW_FOD
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  localparam logic [10:0] ID_VALUE = 11'h2A1;

  logic [1:0]  sclk_s, csn_s, mosi_s;
  logic        sclk_d, csn_d;
  logic        sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_bit;
  state_t      state, state_next;
  logic [4:0]  bit_cnt;
  logic [15:0] sreg;
  logic [10:0] tx;
  logic [10:0] fcw_shadow;
  logic [10:0] rd_word;
  logic [3:0]  hdr_addr;
  logic        take_bit, commit, load_tx, wr_en;
  logic [3:0]  wr_addr;
  logic [10:0] wr_data;

  // Two-flop synchronisers, then registered edge pulses; MOSI is delayed
  // one extra stage so it stays aligned with the SCLK edge pulse.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples values from before the clock edge, whatever the order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_s    <= '0;
      csn_s     <= '0;
      mosi_s    <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      csn_fall  <= 1'b0;
      csn_rise  <= 1'b0;
      mosi_bit  <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[0], SCLK};
      csn_s     <= {csn_s[0], CSN};
      mosi_s    <= {mosi_s[0], MOSI};
      sclk_d    <= sclk_s[1];
      csn_d     <= csn_s[1];
      sclk_rise <= sclk_s[1] & ~sclk_d;
      sclk_fall <= ~sclk_s[1] & sclk_d;
      csn_fall  <= ~csn_s[1] & csn_d;
      csn_rise  <= csn_s[1] & ~csn_d;
      mosi_bit  <= mosi_s[1];
    end
  end

  // A bit is taken on an SCLK rise inside a live frame; a frame start in
  // the same cycle wins and discards that bit.
  assign take_bit = sclk_rise && !csn_d && !csn_fall &&
                    (state == HDR || state == DATA) && (bit_cnt < 5'd16);
  assign commit   = (state == DATA) && (bit_cnt == 5'd16);
  assign hdr_addr = {sreg[2:0], mosi_bit};
  assign load_tx  = (state == HDR) && (state_next == DATA);
  assign wr_addr  = sreg[14:11];
  assign wr_data  = sreg[10:0];
  assign wr_en    = commit && sreg[15];

  // Next-state logic for the frame sequencer.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (csn_rise) begin
      state_next = IDLE;
    end else if (csn_fall) begin
      state_next = HDR;
    end else begin
      case (state)
        HDR:     if (take_bit && bit_cnt == 5'd4) state_next = DATA;
        DATA:    if (bit_cnt == 5'd16) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  // State register, bit counter and receive shift register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sreg    <= '0;
    end else begin
      state <= state_next;
      if (csn_fall) begin
        bit_cnt <= '0;
        sreg    <= '0;
      end else if (take_bit) begin
        sreg    <= {sreg[14:0], mosi_bit};
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // Read mux, zero-extended register contents by address.
  always_comb begin
    rd_word = '0;
    case (hdr_addr)
      4'h0: rd_word = {5'b0, OFSTCALI_EN, DTCCALI_EN, RT_EN, FREQ_C_MODE,
                       FREQ_C_EN, PCALI_EN};
      4'h1: rd_word = {1'b0, PCALI_KS, FREQ_C_KS};
      4'h2: rd_word = {1'b0, PHASE_CTRL};
      4'h3: rd_word = {4'b0, CALIORDER, PSEG, PCALI_FREQDOWN};
      4'h4: rd_word = {1'b0, KC, KB};
      4'h5: rd_word = {6'b0, KD};
      4'h6: rd_word = {1'b0, KDTCB_INIT};
      4'h7: rd_word = {1'b0, KDTCC_INIT};
      4'h8: rd_word = {1'b0, KDTCD_INIT};
      4'h9: rd_word = fcw_shadow;
      4'hA: rd_word = FCW_FOD[21:11];
      4'hF: rd_word = ID_VALUE;
      default: rd_word = '0;
    endcase
  end

  // MISO path: read data loaded at the end of the header, presented MSB
  // first on SCLK falling edges; held low outside the data phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx   <= '0;
      MISO <= 1'b0;
    end else begin
      if (load_tx)
        tx <= rd_word;
      else if (sclk_fall && (state == DATA || state == DONE))
        tx <= {tx[9:0], 1'b0};
      if (csn_d || state == IDLE || state == HDR)
        MISO <= 1'b0;
      else if (sclk_fall)
        MISO <= tx[10];
    end
  end

  // Register file: commits a completed write frame, pulses CFG_UPD for
  // every committed write including the unmapped upper addresses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CFG_UPD        <= 1'b0;
      PCALI_EN       <= 1'b1;
      FREQ_C_EN      <= 1'b0;
      FREQ_C_MODE    <= 1'b0;
      RT_EN          <= 1'b1;
      DTCCALI_EN     <= 1'b0;
      OFSTCALI_EN    <= 1'b0;
      FREQ_C_KS      <= 5'd0;
      PCALI_KS       <= 5'd8;
      PHASE_CTRL     <= 10'd0;
      PCALI_FREQDOWN <= 3'd0;
      PSEG           <= 2'd3;
      CALIORDER      <= 2'd3;
      KB             <= 5'h1D;
      KC             <= 5'h1D;
      KD             <= 5'h1B;
      KDTCB_INIT     <= 10'd390;
      KDTCC_INIT     <= 10'd195;
      KDTCD_INIT     <= 10'd0;
      fcw_shadow     <= 11'd0;
      FCW_FOD        <= 22'h040000;
    end else begin
      CFG_UPD <= wr_en;
      if (wr_en) begin
        case (wr_addr)
          4'h0: begin
            PCALI_EN    <= wr_data[0];
            FREQ_C_EN   <= wr_data[1];
            FREQ_C_MODE <= wr_data[2];
            RT_EN       <= wr_data[3];
            DTCCALI_EN  <= wr_data[4];
            OFSTCALI_EN <= wr_data[5];
          end
          4'h1: begin
            FREQ_C_KS <= wr_data[4:0];
            PCALI_KS  <= wr_data[9:5];
          end
          4'h2: PHASE_CTRL <= wr_data[9:0];
          4'h3: begin
            PCALI_FREQDOWN <= wr_data[2:0];
            PSEG           <= wr_data[4:3];
            CALIORDER      <= wr_data[6:5];
          end
          4'h4: begin
            KB <= wr_data[4:0];
            KC <= wr_data[9:5];
          end
          4'h5: KD         <= wr_data[4:0];
          4'h6: KDTCB_INIT <= wr_data[9:0];
          4'h7: KDTCC_INIT <= wr_data[9:0];
          4'h8: KDTCD_INIT <= wr_data[9:0];
          4'h9: fcw_shadow <= wr_data;
          4'hA: FCW_FOD    <= {wr_data, fcw_shadow};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fod_spi_regs.md
FOD_SPI_REGS -- requirements
Module: fod_spi_regs

Interface
REQ-001 SHALL have ports:
- CLK  in  1  system clock, the only clock domain; must be at least 8x SCLK.
- RST  in  1  reset, synchronous, active-high.
- SCLK  in  1  SPI clock, asynchronous to CLK, mode 0.
- CSN  in  1  SPI chip select, active-low.
- MOSI  in  1  SPI serial data in.
- MISO  out  1  SPI serial data out.
- CFG_UPD  out  1  one-CLK pulse on each committed write.
- PCALI_EN, FREQ_C_EN, FREQ_C_MODE, RT_EN, DTCCALI_EN, OFSTCALI_EN  out  1 each  calibration enables.
- FREQ_C_KS, PCALI_KS, KB, KC, KD  out  5 each  loop gains; KB/KC/KD are two's complement.
- PHASE_CTRL, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT  out  10 each.
- PCALI_FREQDOWN  out  3.
- PSEG, CALIORDER  out  2 each.
- FCW_FOD  out  22  unsigned FCW, 6 integer bits and 16 fractional bits.

Function
REQ-002 SHALL synchronise SCLK, CSN and MOSI through 2 CLK flops each, then edge-detect SCLK and CSN in CLK.
REQ-003 SHALL use a 16-bit frame, MSB first: bit15 = RW (1 = write), bits14:11 = ADDR, bits10:0 = DATA.
REQ-004 SHALL sample MOSI on synchronised SCLK rising edges only while CSN is low.
REQ-005 SHALL clear the bit counter and shift register on a CSN falling edge.
REQ-006 SHALL run a state machine with states IDLE, HDR, DATA, DONE:
- IDLE -> HDR on CSN falling edge.
- HDR -> DATA after the 5th sampled bit.
- DATA -> DONE after the 16th sampled bit.
- Any state -> IDLE on CSN rising edge.
REQ-007 SHALL commit a write in the CLK cycle after the 16th bit is detected (DONE entry), when RW = 1; the target register and CFG_UPD both update on that edge.
REQ-008 Total commit latency SHALL be exactly 4 CLK edges after the first CLK edge that samples the 16th SCLK high.
REQ-009 SHALL use this register map (DATA bit fields):
- 0x0: [0] PCALI_EN, [1] FREQ_C_EN, [2] FREQ_C_MODE, [3] RT_EN, [4] DTCCALI_EN, [5] OFSTCALI_EN.
- 0x1: [4:0] FREQ_C_KS, [9:5] PCALI_KS.
- 0x2: [9:0] PHASE_CTRL.
- 0x3: [2:0] PCALI_FREQDOWN, [4:3] PSEG, [6:5] CALIORDER.
- 0x4: [4:0] KB, [9:5] KC.
- 0x5: [4:0] KD.
- 0x6: KDTCB_INIT.
- 0x7: KDTCC_INIT.
- 0x8: KDTCD_INIT.
- 0x9: FCW_LO shadow [10:0].
- 0xA: FCW_HI [10:0].
- 0xF: read-only ID 11'h2A1.
REQ-010 SHALL make FCW_FOD update atomically:
- A write to 0x9 updates only the shadow.
- A write to 0xA loads FCW_FOD = {DATA, shadow} in one cycle.
- FCW_FOD SHALL never expose a half-written value.
REQ-011 SHALL ignore writes to 0xB-0xF and to unused DATA bits; CFG_UPD still pulses for writes to 0xB-0xF.
REQ-012 Reads SHALL return register contents zero-extended to 11 bits; reads of 0x9 return the shadow; reads of 0xB-0xE return 0.
REQ-013 SHALL handle MISO as follows:
- Latch read data into the output shift register when HDR -> DATA.
- Drive DATA[10] on the next synchronised SCLK falling edge.
- Shift one bit per subsequent falling edge.
- Hold MISO at 0 while CSN is high or during HDR.
REQ-014 SHALL abort a frame when CSN rises before 16 bits: no commit, no CFG_UPD pulse.
REQ-015 SHALL ignore bits beyond the 16th until CSN rises; there SHALL be only one commit per frame.
REQ-016 When a CSN falling edge and an SCLK rising edge are detected in the same CLK cycle, the frame start SHALL win and that bit SHALL be discarded.

Reset
REQ-017 On RST = 1 at a CLK edge, the block SHALL go to IDLE, clear the counter, shift register and sync flops, and set CFG_UPD = 0 and MISO = 0.
REQ-018 Reset values SHALL be:
- PCALI_EN = 1, RT_EN = 1; all other enables 0.
- FREQ_C_KS = 0, PCALI_KS = 8, PHASE_CTRL = 0, PCALI_FREQDOWN = 0.
- PSEG = 3, CALIORDER = 3.
- KB = 5'h1D, KC = 5'h1D, KD = 5'h1B.
- KDTCB_INIT = 390, KDTCC_INIT = 195, KDTCD_INIT = 0.
- FCW_FOD = 22'h040000 (4.0); shadow = 0.
REQ-019 RST asserted mid-frame SHALL discard the frame; any SCLK edges after release SHALL be ignored until the next CSN falling edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then read 0xF -> MISO returns 11'h2A1; read 0x6 -> 390.
- Write 0x4 = {KC = 5'd2, KB = 5'h1F} -> KB = -1, KC = 2; CFG_UPD pulses once; all other outputs unchanged.
- Write 0x9 = 11'h147, then 0xA = 11'h087 -> FCW_FOD stays 22'h040000 after the first frame and becomes 22'h043947 (approx. 4.2237) after the second.
- Write 0x2 with CSN raised after 12 bits -> PHASE_CTRL stays 0; no CFG_UPD.
- Write 0x0 = 0 with 20 SCLK pulses in one CSN-low window -> single commit; PCALI_EN = 0, RT_EN = 0.
- Assert RST during the 10th bit of a write to 0x7, then send a clean write 0x7 = 100 -> KDTCC_INIT goes 195, then 100.
